// File: rtl/bin_to_seg_seq.sv
// Purpose : sequential binary-to-7-segment converter (double-dabble, DIGITS active-low digits).
// Latency : done pulses in the (WIDTH+1)th cycle after the accepting edge; seg updates on that edge.
// Backpr. : start is ignored while busy=1; optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module bin_to_seg_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      v,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint MAX_VAL = (longint'(1) << WIDTH) - 1;

    // Reject configurations whose display cannot hold the largest input value.
    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("bin_to_seg_seq: WIDTH must be in 1..16");
        end
        if (DIGITS < 1 || pow10(DIGITS) <= MAX_VAL) begin : g_bad_digits
            $error("bin_to_seg_seq: DIGITS too small, need 10**DIGITS > 2**WIDTH-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       bin_q, bin_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7*DIGITS-1:0]    seg_q, seg_d;

    // One BCD digit to active-low segments, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Whole BCD register to segment pattern; the ones digit is never blanked.
    function automatic logic [7*DIGITS-1:0] encode(input logic [4*DIGITS-1:0] bcd);
        logic [7*DIGITS-1:0] r;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        r    = '1;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd[4*k +: 4] != 4'd0 || k == 0) begin
                lead = 1'b0;
            end
            r[7*k +: 7] = lead ? 7'h7F : seg7(bcd[4*k +: 4]);
        end
`else
        r = '1;
        for (int k = 0; k < DIGITS; k++) begin
            r[7*k +: 7] = seg7(bcd[4*k +: 4]);
        end
`endif
        return r;
    endfunction

    // State register; reset wins over everything, including a conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE accepts start, SHIFT runs WIDTH cycles, OUT lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state only.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == OUT);
    end

    // Datapath next state: capture, double-dabble step, and the final segment load.
    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d = v;
                    bcd_d = '0;
                    cnt_d = CNT_W'(WIDTH);
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q - 1'b1;
                // The last shift lands on the edge that enters OUT, so seg
                // changes exactly when done rises.
                if (cnt_q == CNT_W'(1)) begin
                    seg_d = encode(bcd_d);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset blanks every digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            seg_q <= '1;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;

endmodule

// File: tb/tb_bin_to_seg_seq.sv
// Bench for bin_to_seg_seq: 8-bit/3-digit and 4-bit/2-digit instances,
// decimal reference model, queue scoreboard popped on each done pulse.
module tb_bin_to_seg_seq;

    logic        clk = 1'b0;
    logic        rst, start, start4;
    logic [7:0]  v;
    logic [3:0]  v4;
    logic        busy, done, busy4, done4;
    logic [20:0] seg;
    logic [13:0] seg4;

    always #5 clk = ~clk;

    bin_to_seg_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .v(v),
        .busy(busy), .done(done), .seg(seg)
    );

    bin_to_seg_seq #(.WIDTH(4), .DIGITS(2)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .v(v4),
        .busy(busy4), .done(done4), .seg(seg4)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        logic [20:0] s;
        int          acyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_edge = 1'b1;

    always @(posedge clk) begin
        cyc      = cyc + 1;
        rst_edge = rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain decimal digits, then table lookup and optional leading-zero blanking.
    function automatic logic [20:0] model(input int val, input int nd);
        int          d[3];
        int          x;
        int          msd;
        logic [20:0] r;
        x   = val;
        msd = 0;
        r   = '1;
        for (int k = 0; k < 3; k++) begin
            d[k] = x % 10;
            x    = x / 10;
            if (d[k] != 0) msd = k;
        end
        for (int k = 0; k < nd; k++) begin
            r[7*k +: 7] = (LZB && k > msd) ? 7'h7F : SEG_TBL[d[k]];
        end
        return r;
    endfunction

    // Monitor for the 8-bit instance: result, latency, busy length, seg stability.
    exp_t        e8;
    int          busy_run = 0;
    logic [20:0] prev_seg;
    bit          seg_init = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1) busy_run++; else busy_run = 0;
        if (done === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: done with nothing pending, seg=%h", seg);
            end else begin
                e8 = q8.pop_front();
                chk("seg8", 32'(seg), 32'(e8.s));
                chk("latency8", cyc, e8.acyc + 8);
                chk("busy_len8", busy_run, 9);
            end
        end
        if (seg_init && seg !== prev_seg) begin
            checks++;
            if (!done && !rst_edge) begin
                errors++;
                $display("FAIL seg_stable8: seg changed to %h from %h without done", seg, prev_seg);
            end
        end
        prev_seg = seg;
        seg_init = 1'b1;
    end

    // Monitor for the 4-bit instance.
    exp_t e4;
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done4: done with nothing pending, seg=%h", seg4);
            end else begin
                e4 = q4.pop_front();
                chk("seg4", 32'(seg4), 32'(e4.s[13:0]));
                chk("latency4", cyc, e4.acyc + 4);
            end
        end
    end

    // All drivers are entered 1 time unit after a rising edge.
    task automatic wait_idle8(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (busy === 1'b0);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout8: busy=%b stuck", busy);
        end
    endtask

    task automatic issue8(input logic [7:0] val, input logic [20:0] exp, output int acyc);
        bit ok;
        wait_idle8(ok);
        acyc = -1;
        if (ok) begin
            start = 1'b1;
            v     = val;
            @(posedge clk); #1;
            start = 1'b0;
            v     = 8'($urandom);
            acyc  = cyc;
            q8.push_back('{exp, acyc});
        end
    endtask

    task automatic issue4(input logic [3:0] val, input logic [20:0] exp);
        int n = 0;
        while (busy4 !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy4 !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL timeout4: busy=%b stuck", busy4);
        end else begin
            start4 = 1'b1;
            v4     = val;
            @(posedge clk); #1;
            start4 = 1'b0;
            v4     = 4'($urandom);
            q4.push_back('{exp, cyc});
        end
    endtask

    initial begin
        int  a1, a2, val, n;
        bit  ok;
        rst    = 1'b1;
        start  = 1'b0;
        start4 = 1'b0;
        v      = '0;
        v4     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg8", 32'(seg), 32'h1FFFFF);
        chk("rst_busy8", 32'(busy), 32'd0);
        chk("rst_done8", 32'(done), 32'd0);
        chk("rst_seg4", 32'(seg4), 32'h3FFF);
        rst = 1'b0;

        // Directed values.
        issue8(8'd255, {7'h24, 7'h12, 7'h12}, a1);
        issue8(8'd7, LZB ? {7'h7F, 7'h7F, 7'h78} : {7'h40, 7'h40, 7'h78}, a1);
        issue8(8'd0, LZB ? {7'h7F, 7'h7F, 7'h40} : {7'h40, 7'h40, 7'h40}, a1);

        // Start while busy is ignored; start right after done is accepted at once.
        issue8(8'd100, {7'h79, 7'h40, 7'h40}, a1);
        @(posedge clk); #1;
        start = 1'b1;
        v     = 8'd42;
        @(posedge clk); #1;
        start = 1'b0;
        issue8(8'd42, LZB ? {7'h7F, 7'h19, 7'h24} : {7'h40, 7'h19, 7'h24}, a2);
        chk("back_to_back", a2, a1 + 10);

        // Reset in the 4th SHIFT cycle aborts without done or seg update.
        wait_idle8(ok);
        start = 1'b1;
        v     = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_seg", 32'(seg), 32'h1FFFFF);
        repeat (12) begin
            @(posedge clk); #1;
        end

        // Random values with random gaps.
        for (int i = 0; i < 40; i++) begin
            val = int'($urandom_range(0, 255));
            issue8(8'(val), model(val, 3), a1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        // 4-bit instance sweep, plus a literal check of 13.
        for (int i = 0; i < 16; i++) begin
            issue4(4'(i), model(i, 2));
        end
        issue4(4'd13, {7'h00, 7'h79, 7'h30});

        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q8.size() != 0 || q4.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d/%0d results never arrived", q8.size(), q4.size());
        end
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
